field_pow2_scale: RTL and testbench

- Multi-lane GF(p) scaler: computes a·2^-k (halve mode) or a·2^k (double mode) mod p.
- Each of N_CHAN lanes holds an independent operand; all lanes share one shift count k and one mode.
- Iterates one conditional-add-and-shift step per cycle, so no multiplier is used.
- Sits beside the field add/mul units in the sumcheck datapath; replaces repeated single halvings when dividing by powers of two.

---
 rtl/field_pow2_pkg.sv | 26 ++
 rtl/field_pow2_lane.sv | 37 +++
 rtl/field_pow2_scale.sv | 102 ++++++++++
 tb/tb_field_pow2_scale.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/field_pow2_pkg.sv
// Shared types and the single halve/double step for the GF(p) power-of-two scaler.
// The step is evaluated on a 64-bit word, so lanes up to 63 bits wide can use it.
package field_pow2_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int NBITS_DEF = 61;
  localparam int WORK_W    = NBITS_DEF + 1;
  localparam int STEP_W    = 64;

  // Halve: (x + p*x[0]) >> 1. Double: 2x, minus p once if it reaches p. Needs x < p.
  function automatic logic [STEP_W-1:0] step(input logic [STEP_W-1:0] x,
                                             input logic [STEP_W-1:0] p,
                                             input logic              dbl);
    logic [STEP_W-1:0] y;
    if (dbl) begin
      y = x << 1;
      if (y >= p) y = y - p;
    end else begin
      y = x[0] ? (x + p) : x;
      y = y >> 1;
    end
    return y;
  endfunction

endpackage

// File: rtl/field_pow2_lane.sv
// One lane: working register loaded with the operand, then stepped once per cycle.
// Latency: load/step visible one edge later; no backpressure, the top sequences it.
module field_pow2_lane
  import field_pow2_pkg::*;
#(
  parameter int               NBITS = WORK_W - 1,
  parameter logic [NBITS-1:0] PRIME = '1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             dbl_i,
  input  logic [NBITS-1:0] a_i,
  output logic [NBITS-1:0] x_o
);

  logic [NBITS-1:0] x_q, x_d;

  // Every step result stays below p, so NBITS bits of state suffice.
  always_comb begin
    x_d = x_q;
    if (load_i) begin
      x_d = a_i;
    end else if (step_i) begin
      x_d = NBITS'(step(STEP_W'(x_q), STEP_W'(PRIME), dbl_i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) x_q <= '0;
    else       x_q <= x_d;
  end

  assign x_o = x_q;

endmodule

// File: rtl/field_pow2_scale.sv
// N_CHAN-lane a*2^-k / a*2^k mod p, one step per cycle; result k+2 edges after en.
// en is only taken while ready is high; requests during an operation are dropped.
module field_pow2_scale
  import field_pow2_pkg::*;
#(
  parameter int               NBITS  = 61,
  parameter logic [NBITS-1:0] PRIME  = 61'h1FFFFFFFFFFFFFFF,
  parameter int               N_CHAN = 4,
  parameter int               KBITS  = 6
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    en,
  input  logic                    dbl,
  input  logic [KBITS-1:0]        k,
  input  logic [N_CHAN*NBITS-1:0] a,
  output logic                    ready_pulse,
  output logic                    ready,
  output logic [N_CHAN*NBITS-1:0] c
);

  state_t                  state_q, state_d;
  logic [KBITS-1:0]        cnt_q, cnt_d;
  logic                    dbl_q, dbl_d;
  logic                    ready_q, ready_d;
  logic                    pulse_q, pulse_d;
  logic [N_CHAN*NBITS-1:0] c_q, c_d;
  logic [N_CHAN*NBITS-1:0] work;
  logic                    load, stp;

  for (genvar i = 0; i < N_CHAN; i++) begin : g_lane
    field_pow2_lane #(.NBITS(NBITS), .PRIME(PRIME)) u_lane (
      .clk    (clk),
      .rstb   (rstb),
      .load_i (load),
      .step_i (stp),
      .dbl_i  (dbl_q),
      .a_i    (a[i*NBITS +: NBITS]),
      .x_o    (work[i*NBITS +: NBITS])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dbl_d   = dbl_q;
    ready_d = ready_q;
    pulse_d = 1'b0;
    c_d     = c_q;
    load    = 1'b0;
    stp     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          load    = 1'b1;
          cnt_d   = k;
          dbl_d   = dbl;
          ready_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          stp   = 1'b1;
          cnt_d = cnt_q - KBITS'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        c_d     = work;
        pulse_d = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dbl_q   <= 1'b0;
      ready_q <= 1'b1;
      pulse_q <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dbl_q   <= dbl_d;
      ready_q <= ready_d;
      pulse_q <= pulse_d;
      c_q     <= c_d;
    end
  end

  assign ready_pulse = pulse_q;
  assign ready       = ready_q;
  assign c           = c_q;

endmodule

// File: tb/tb_field_pow2_scale.sv
// Bench for field_pow2_scale: small field p=13 with random ops against a modular-arithmetic
// model, plus one op on the default 61-bit Mersenne field.
module tb_field_pow2_scale;

  localparam int P = 13;

  logic        clk;
  logic        rstb;
  logic        en, dbl;
  logic [2:0]  k;
  logic [15:0] a, c;
  logic        ready_pulse, ready;

  logic         en2, dbl2;
  logic [5:0]   k2;
  logic [243:0] a2, c2;
  logic         rp2, r2;

  int checks = 0;
  int errors = 0;

  field_pow2_scale #(.NBITS(4), .PRIME(4'd13), .N_CHAN(4), .KBITS(3)) dut (
    .clk(clk), .rstb(rstb), .en(en), .dbl(dbl), .k(k), .a(a),
    .ready_pulse(ready_pulse), .ready(ready), .c(c)
  );

  field_pow2_scale dut_big (
    .clk(clk), .rstb(rstb), .en(en2), .dbl(dbl2), .k(k2), .a(a2),
    .ready_pulse(rp2), .ready(r2), .c(c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // a * 2^k mod p, or the unique y in [0,p) with y * 2^k == a (mod p).
  function automatic int ref_lane(input int x, input int kk, input bit dd);
    int pw = 1;
    for (int i = 0; i < kk; i++) pw = (pw * 2) % P;
    if (dd) return (x * pw) % P;
    for (int y = 0; y < P; y++) if ((y * pw) % P == x) return y;
    return -1;
  endfunction

  function automatic logic [15:0] ref_vec(input logic [15:0] av, input int kk, input bit dd);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'(ref_lane(int'(av[i*4 +: 4]), kk, dd));
    return r;
  endfunction

  function automatic logic [15:0] rand_a();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'($urandom_range(P - 1, 0));
    return r;
  endfunction

  function automatic logic [15:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {4'(l3), 4'(l2), 4'(l1), 4'(l0)};
  endfunction

  // Called at a negedge; returns at the negedge where ready_pulse is seen.
  // poke>=0 raises en with a different operand in that busy cycle.
  task automatic run_op(input logic [15:0] av, input int kk, input bit dd, input int poke);
    int n;
    logic [15:0] exp;
    for (int i = 0; i < 4; i++) assert (av[i*4 +: 4] < P);
    exp = ref_vec(av, kk, dd);
    chk("ready_before_start", ready, 1'b1);
    en = 1'b1; a = av; k = 3'(kk); dbl = dd;
    @(posedge clk); @(negedge clk);
    en = 1'b0; a = 16'($urandom);
    n = 0;
    while (n < 20 && !ready_pulse) begin
      chk("busy_ready_pulse", {62'd0, ready, ready_pulse}, 64'd0);
      if (n == poke) begin
        en = 1'b1; a = ~av; k = 3'($urandom); dbl = ~dd;
      end else begin
        en = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      n++;
    end
    en = 1'b0;
    chk("latency", n, kk + 2);
    chk("result", c, exp);
    chk("ready_at_done", ready, 1'b1);
  endtask

  task automatic pulse_gap();
    @(posedge clk); @(negedge clk);
    chk("pulse_one_cycle", ready_pulse, 1'b0);
  endtask

  initial begin
    int n;
    logic [15:0] hold;
    rstb = 1'b0; en = 1'b0; dbl = 1'b0; k = '0; a = '0;
    en2 = 1'b0; dbl2 = 1'b0; k2 = '0; a2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_c", c, 16'd0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_pulse", ready_pulse, 1'b0);
    rstb = 1'b1;
    @(negedge clk);

    run_op(pack4(5, 4, 0, 12), 1, 1'b0, -1);
    chk("halve_k1", c, pack4(9, 2, 0, 6));
    pulse_gap();
    run_op(pack4(5, 1, 7, 12), 2, 1'b0, -1);
    chk("halve_k2", c, pack4(11, 10, 5, 3));
    pulse_gap();
    run_op(pack4(12, 5, 0, 1), 3, 1'b1, -1);
    chk("double_k3", c, pack4(5, 1, 0, 8));
    pulse_gap();
    run_op(pack4(7, 3, 2, 9), 0, 1'b0, -1);
    chk("k0_halve", c, pack4(7, 3, 2, 9));
    pulse_gap();
    run_op(pack4(7, 3, 2, 9), 0, 1'b1, -1);
    chk("k0_double", c, pack4(7, 3, 2, 9));
    pulse_gap();

    run_op(pack4(1, 2, 3, 4), 5, 1'b0, 2);
    hold = c;
    pulse_gap();
    chk("c_holds", c, hold);
    // Back-to-back: next en shares the cycle with the previous pulse.
    run_op(pack4(6, 8, 10, 11), 4, 1'b1, -1);
    run_op(pack4(2, 0, 12, 5), 3, 1'b0, -1);
    pulse_gap();

    for (int t = 0; t < 30; t++) begin
      run_op(rand_a(), int'($urandom_range(7, 0)), 1'($urandom), ($urandom_range(3, 0) == 0) ? 1 : -1);
      if ($urandom_range(1, 0) == 1) pulse_gap();
    end
    pulse_gap();

    // Reset during RUN discards the operation.
    en = 1'b1; a = pack4(3, 3, 3, 3); k = 3'd6; dbl = 1'b0;
    @(posedge clk); @(negedge clk);
    en = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rstb = 1'b0;
    @(posedge clk); @(negedge clk);
    rstb = 1'b1;
    chk("abort_c", c, 16'd0);
    chk("abort_ready", ready, 1'b1);
    chk("abort_pulse", ready_pulse, 1'b0);
    n = 0;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      if (ready_pulse) n++;
    end
    chk("abort_no_late_pulse", n, 0);

    // Default field: 1 / 2 mod (2^61-1) = 2^60.
    en2 = 1'b1; dbl2 = 1'b0; k2 = 6'd1;
    a2 = {61'd0, 61'd3, 61'd2, 61'd1};
    @(posedge clk); @(negedge clk);
    en2 = 1'b0;
    n = 0;
    while (n < 10 && !rp2) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    chk("big_latency", n, 3);
    chk("big_lane0", c2[0 +: 61], 64'h1000_0000_0000_0000);
    chk("big_lane1", c2[61 +: 61], 64'd1);
    chk("big_lane2", c2[122 +: 61], 64'h1000_0000_0000_0001);
    chk("big_lane3", c2[183 +: 61], 64'd0);
    chk("big_ready", r2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
